// File: rtl/shifter_stream_16.sv
// shifter_stream_16 -- flow-controlled, registered front end for the 16-bit
// rotator. Requests queue in a DEPTH-entry FIFO; the head entry is rotated
// combinationally and captured in an output register with its own handshake.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (in_ready from registered state)
//   in_data/amt/lr      : word, rotate amount 0-15, direction (1 = left)
//   out_valid/out_ready : result handshake
//   out_data/out_lr     : rotated word and the direction used
//   op_count            : completed output handshakes, saturating at 0xFFFF

// Pure combinational rotator: lr=0 rotates right, lr=1 rotates left.
module multifunction_shifter_16 (
   input  logic [15:0] data,
   input  logic [3:0]  amt,
   input  logic        lr,
   output logic [15:0] result
);
   logic [31:0] dbl, r_sh, l_sh;

   // Doubling the word makes the wrapped bits fall out of a plain shift.
   assign dbl    = {data, data};
   assign r_sh   = dbl >> amt;
   assign l_sh   = dbl << amt;
   assign result = lr ? l_sh[31:16] : r_sh[15:0];
endmodule

module shifter_stream_16 #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic [3:0]  in_amt,
   input  logic        in_lr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_lr,
   output logic [15:0] op_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  amt;
      logic        lr;
   } req_t;

   req_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_next;
   logic          in_ready_r, out_valid_r;
   logic          push, pop;
   req_t          head;
   logic [15:0]   rot;

   assign push = in_valid && in_ready_r;
   // Refill the output register whenever it is empty or being drained.
   assign pop  = (count != '0) && (!out_valid_r || out_ready);
   assign head = mem[rd_ptr];

   multifunction_shifter_16 u_rot (
      .data   (head.data),
      .amt    (head.amt),
      .lr     (head.lr),
      .result (rot)
   );

   always_comb begin
      count_next = count;
      if (push && !pop)      count_next = count + ONE;
      else if (!push && pop) count_next = count - ONE;
   end

   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr] <= '{data: in_data, amt: in_amt, lr: in_lr};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_data    <= 16'h0000;
         out_lr      <= 1'b0;
         op_count    <= 16'h0000;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
         // Registered so in_ready never sees a combinational input path.
         in_ready_r <= (count_next != FULL);
         if (pop) begin
            out_valid_r <= 1'b1;
            out_data    <= rot;
            out_lr      <= head.lr;
         end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end
         if (out_valid_r && out_ready && op_count != 16'hFFFF)
            op_count <= op_count + 16'd1;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
endmodule

// File: tb/tb_shifter_stream_16.sv
// Bench for shifter_stream_16: directed cases with literal results plus a
// queue-based reference model checked on every clock.
module tb_shifter_stream_16;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_amt;
   logic        in_lr;
   logic        out_valid, out_ready;
   logic [15:0] out_data;
   logic        out_lr;
   logic [15:0] op_count;

   int n_chk = 0;
   int n_pass = 0;

   shifter_stream_16 #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_amt(in_amt), .in_lr(in_lr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_lr(out_lr), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference rotate: one bit position at a time.
   function automatic logic [15:0] ref_rot(input logic [15:0] d, input logic [3:0] a, input logic l);
      logic [15:0] r = d;
      for (int i = 0; i < int'(a); i++)
         r = l ? {r[14:0], r[15]} : {r[0], r[15:1]};
      return r;
   endfunction

   // ---------------- model + per-cycle compare ----------------
   logic [16:0] q[$];
   logic [15:0] mop = 16'h0;
   logic        stall = 1'b0;
   logic [16:0] hold;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         mop   = 16'h0;
         stall = 1'b0;
      end else begin
         chk("op_count", {16'h0, op_count}, {16'h0, mop});
         if (stall) begin
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_hold", {15'h0, out_lr, out_data}, {15'h0, hold});
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", {15'h0, out_lr, out_data}, 32'hFFFF_FFFF);
            end else begin
               logic [16:0] e;
               e = q.pop_front();
               chk("stream_data", {16'h0, out_data}, {16'h0, e[15:0]});
               chk("stream_lr", {31'h0, out_lr}, {31'h0, e[16]});
            end
            if (mop != 16'hFFFF) mop = mop + 16'd1;
         end
         stall = out_valid && !out_ready;
         hold  = {out_lr, out_data};
         if (in_valid && in_ready) q.push_back({in_lr, ref_rot(in_data, in_amt, in_lr)});
      end
   end

   // ---------------- drivers (called at #1 after a posedge) ----------------
   task automatic push(input logic [15:0] d, input logic [3:0] a, input logic l);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_amt = a; in_lr = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t++;
         if (t > 1000) begin
            chk("push_timeout", 32'h0, 32'h1);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      chk("in_ready_in_reset", {31'h0, in_ready}, 32'h1);
      step();
      reset = 1'b0;
   endtask

   // Push one request on an idle stage and check the result 2 edges later.
   task automatic rot_check(input string name, input logic [15:0] d, input logic [3:0] a,
                            input logic l, input logic [15:0] exp);
      push(d, a, l);
      chk({name, "_lat"}, {31'h0, out_valid}, 32'h0);
      step();
      chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
      chk({name, "_data"}, {16'h0, out_data}, {16'h0, exp});
      chk({name, "_lr"}, {31'h0, out_lr}, {31'h0, l});
      step();
   endtask

   bit rnd_done;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_lr = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_data", {16'h0, out_data}, 32'h0);
      chk("rst_lr", {31'h0, out_lr}, 32'h0);
      chk("rst_opcnt", {16'h0, op_count}, 32'h0);
      chk("rst_ready", {31'h0, in_ready}, 32'h1);

      // single right rotate
      out_ready = 1'b1;
      rot_check("rotr1", 16'h8001, 4'd1, 1'b0, 16'hC000);
      chk("rotr1_opcnt", {16'h0, op_count}, 32'h1);
      chk("rotr1_drop", {31'h0, out_valid}, 32'h0);

      // left rotate, zero amount, max amount
      rot_check("rotl4", 16'h8001, 4'd4, 1'b1, 16'h0018);
      rot_check("rot0", 16'h1234, 4'd0, 1'b1, 16'h1234);
      rot_check("rotr15", 16'h00FF, 4'd15, 1'b0, 16'h01FE);

      // back-pressure fill and drain
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) push(16'(i), 4'd1, 1'b1);
      chk("bp_full", {31'h0, in_ready}, 32'h0);
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         chk("bp_valid", {31'h0, out_valid}, 32'h1);
         chk("bp_order", {16'h0, out_data}, 32'(2 * i));
         step();
      end
      chk("bp_empty", {31'h0, out_valid}, 32'h0);
      chk("bp_opcnt", {16'h0, op_count}, 32'd5);

      // randomized streaming with random out_ready
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               push(16'($urandom), 4'($urandom), 1'($urandom));
               repeat ($urandom_range(0, 1)) step();
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = 1'($urandom);
               step();
            end
         end
      join
      out_ready = 1'b1;
      for (int t = 0; t < 50 && (q.size() != 0 || out_valid); t++) step();
      chk("rnd_drained", 32'(q.size()), 32'h0);
      chk("rnd_idle", {31'h0, out_valid}, 32'h0);

      // reset mid-operation
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(16'hA5A5 + 16'(i), 4'd3, 1'b0);
      do_reset();
      chk("mid_valid", {31'h0, out_valid}, 32'h0);
      chk("mid_opcnt", {16'h0, op_count}, 32'h0);
      chk("mid_ready", {31'h0, in_ready}, 32'h1);
      out_ready = 1'b1;
      repeat (3) begin
         step();
         chk("mid_no_old", {31'h0, out_valid}, 32'h0);
      end
      rot_check("mid_new", 16'h0F0F, 4'd2, 1'b1, 16'h3C3C);

      // op_count saturation with back-to-back traffic
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 65540; i++) push(16'($urandom), 4'($urandom), 1'($urandom));
      repeat (3) step();
      chk("sat_opcnt", {16'h0, op_count}, 32'hFFFF);
      rot_check("sat_data", 16'h8001, 4'd1, 1'b0, 16'hC000);
      chk("sat_hold", {16'h0, op_count}, 32'hFFFF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/shifter_stream_16.md
# shifter_stream_16

Registered, flow-controlled front end for the 16-bit rotate datapath (`multifunction_shifter_16`). Rotate requests arrive on a valid/ready stream and wait in a small request FIFO. The head request passes through one internal `multifunction_shifter_16` instance. Results are held in an output register with its own valid/ready handshake. This turns the purely combinational rotator into a pipelined stage that accepts one request per cycle.

## Interface
- `DEPTH`, default 4: request FIFO entries. Must be a power of two, ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: FIFO can accept a request.
- `in_data` input 16: word to rotate.
- `in_amt` input 4: rotate amount, 0–15.
- `in_lr` input 1: direction; 0 = rotate right, 1 = rotate left.
- `out_valid` output 1: result register holds a result.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output 16: rotated word.
- `out_lr` output 1: direction used for `out_data`.
- `op_count` output 16: number of completed output handshakes, saturating.

## Operation
- **Input handshake.** A request is accepted on a rising edge where `in_valid && in_ready`. It is written at `wr_ptr`, which then increments modulo DEPTH.
- **`in_ready`.** `in_ready = (count != DEPTH)`.
  - Driven from registered state only.
  - Never depends on `out_ready` or `in_valid`.
- **Output register load.** The register loads when the FIFO is non-empty and `(!out_valid || out_ready)`. On load:
  - `out_data` takes the shifter result for the head entry's data, amount and direction.
  - `out_lr` takes the head entry's direction.
  - `out_valid` is set to 1.
  - `rd_ptr` increments modulo DEPTH.
- **Output hold.** If `out_valid && out_ready` and the FIFO is empty, `out_valid` goes to 0. `out_data` and `out_lr` hold their last values.
- **Counts.**
  - `count` goes +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
  - Push while full is impossible because `in_ready` is 0.
  - Pop while empty is impossible by construction.
- **Pointer wrap.** `wr_ptr` and `rd_ptr` are log2(DEPTH) bits. `count` is log2(DEPTH)+1 bits.
- **`op_count`.** Increments on each `out_valid && out_ready` edge and saturates at 0xFFFF.
- **Stall.** While `out_valid && !out_ready`, `out_data` and `out_lr` are stable and no pop occurs.
- **Reset values.**
  - `count=0`, `wr_ptr=0`, `rd_ptr=0`.
  - `out_valid=0`, `out_data=0x0000`, `out_lr=0`, `op_count=0`.
  - `in_ready=1` one cycle after reset deasserts. While `reset` is high, `in_ready` is 1 but no push takes effect.
- **Reset mid-operation.** Reset discards all buffered requests and the pending result. Nothing accepted before the reset edge ever appears at the output.

## Timing
- **Latency.** A request accepted at edge k, with FIFO empty and output free, gives `out_valid=1` with its result after edge k+1. Accept to result is 2 edges.
- **Throughput.** One request per cycle sustained while `out_ready=1`.
- **Back-pressure.** With `out_ready=0`, the stage absorbs DEPTH requests plus 1 in the output register; `in_ready` drops after the DEPTH-th push.
- **Order.** Results leave strictly in acceptance order.
- **Combinational paths.** None from any input to any output. The only combinational datapath is FIFO head → shifter → output register D input.

## Test plan
- **Single right rotate.** Reset, then push data=0x8001, amt=1, lr=0 with `out_ready=1`. Required: `out_valid` rises 2 edges after accept, `out_data=0xC000`, `out_lr=0`, `op_count=1`.
- **Left rotate and zero amount.**
  - Push 0x8001, amt=4, lr=1: `out_data=0x0018`.
  - Then push 0x1234, amt=0, lr=1: `out_data=0x1234`.
  - Then push 0x00FF, amt=15, lr=0: `out_data=0x01FE`.
- **Back-pressure fill and drain.** Hold `out_ready=0` and push 0x0001..0x0005 (amt=1, lr=1), DEPTH=4.
  - `in_ready` goes 0 after the 4th FIFO push; the 5th waits.
  - Release `out_ready`: outputs appear in order 0x0002, 0x0004, 0x0006, 0x0008, 0x000A, one per cycle.
  - `op_count=5` at the end.
- **Streaming with random `out_ready`.** 200 random requests against a reference rotate model. Required: no drop, no duplicate, in-order, and `out_data` stable during every stall.
- **Reset mid-operation.** Fill with 3 requests, output stalled, then assert `reset` for 1 cycle.
  - Required: `out_valid=0`, `op_count=0`, `in_ready=1` next cycle.
  - None of the 3 results ever appears.
  - A new request gives its correct result 2 edges after accept.
- **`op_count` saturation.** Force 65,537 output handshakes with back-to-back traffic. Required: `op_count` holds at 0xFFFF and data results remain correct.
